// File: rtl/tts_eval.sv
// tts_eval: pipelined tick-to-trade strategy evaluator.
// Maps each tick's symbol to a strategy index, reads that strategy's price
// threshold, quantity cap and order template, and emits a clipped order.
// Optional build macro: TTS_EVAL_STATS_EN enables the statistics counters;
// when it is undefined, stat_ticks, stat_orders and stat_drops are tied to 0.
`timescale 1ns/1ps

module tts_eval #(
   parameter int unsigned SYM_ID_WIDTH = 8,
   parameter int unsigned IDX_WIDTH    = 6,
   parameter int unsigned PRICE_WIDTH  = 32,
   parameter int unsigned QTY_WIDTH    = 32,
   parameter int unsigned ORDER_WIDTH  = 64,
   localparam int unsigned ADDR_WIDTH  = (SYM_ID_WIDTH > IDX_WIDTH) ? SYM_ID_WIDTH : IDX_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    tick_valid,
   output logic                    tick_ready,
   input  logic [SYM_ID_WIDTH-1:0] tick_sym,
   input  logic [PRICE_WIDTH-1:0]  tick_price,
   input  logic [QTY_WIDTH-1:0]    tick_qty,
   input  logic                    strat_en,
   input  logic                    host_wr,
   input  logic [1:0]              host_sel,
   input  logic [ADDR_WIDTH-1:0]   host_addr,
   input  logic [ORDER_WIDTH-1:0]  host_wdata,
   output logic                    ord_valid,
   input  logic                    ord_ready,
   output logic [ORDER_WIDTH-1:0]  ord_tmpl,
   output logic [PRICE_WIDTH-1:0]  ord_price,
   output logic [QTY_WIDTH-1:0]    ord_qty,
   output logic [IDX_WIDTH-1:0]    ord_idx,
   output logic [31:0]             stat_ticks,
   output logic [31:0]             stat_orders,
   output logic [31:0]             stat_drops
);

   localparam int unsigned SYM_DEPTH = 2 ** SYM_ID_WIDTH;
   localparam int unsigned IDX_DEPTH = 2 ** IDX_WIDTH;

   // Host-writable tables; only the valid and armed bits are reset.
   logic [IDX_WIDTH-1:0]   map_idx  [SYM_DEPTH];
   logic [SYM_DEPTH-1:0]   map_vld;
   logic [PRICE_WIDTH-1:0] thr_mem  [IDX_DEPTH];
   logic [QTY_WIDTH-1:0]   cap_mem  [IDX_DEPTH];
   logic [ORDER_WIDTH-1:0] tmpl_mem [IDX_DEPTH];
   logic [IDX_DEPTH-1:0]   side_mem;
   logic [IDX_DEPTH-1:0]   os_mem;
   logic [IDX_DEPTH-1:0]   armed;

   // Pipeline registers: S1 tick capture, S2 map result, S3 strategy entry.
   logic                   s1_valid, s2_valid, s3_valid;
   logic [SYM_ID_WIDTH-1:0] s1_sym;
   logic [PRICE_WIDTH-1:0] s1_price, s2_price, s3_price;
   logic [QTY_WIDTH-1:0]   s1_qty, s2_qty, s3_qty;
   logic                   s2_vld, s3_vld;
   logic [IDX_WIDTH-1:0]   s2_idx, s3_idx;
   logic [PRICE_WIDTH-1:0] s3_thr;
   logic                   s3_side, s3_os, s3_armed;
   logic [QTY_WIDTH-1:0]   s3_cap;
   logic [ORDER_WIDTH-1:0] s3_tmpl;

   logic                   advance_c;
   logic                   tick_acc_c;
   logic                   wr_map_c, wr_price_c, wr_cap_c, wr_tmpl_c;
   logic [SYM_ID_WIDTH-1:0] host_sym_c;
   logic [IDX_WIDTH-1:0]   host_idx_c;
   logic                   px_ok_c, trig_c, load_c, drop_c, arm_clr_c;
   logic [QTY_WIDTH-1:0]   clip_qty_c;

   // Global stall: every stage moves only when the output slot can take data.
   assign advance_c  = !ord_valid || ord_ready;
   assign tick_ready = advance_c;
   assign tick_acc_c = tick_valid && advance_c;

   assign host_sym_c = host_addr[SYM_ID_WIDTH-1:0];
   assign host_idx_c = host_addr[IDX_WIDTH-1:0];
   assign wr_map_c   = host_wr && (host_sel == 2'd0);
   assign wr_price_c = host_wr && (host_sel == 2'd1);
   assign wr_cap_c   = host_wr && (host_sel == 2'd2);
   assign wr_tmpl_c  = host_wr && (host_sel == 2'd3);

   // S3 evaluation: trigger decision, clipped quantity, one-shot disarm.
   assign px_ok_c    = s3_side ? (s3_price >= s3_thr) : (s3_price <= s3_thr);
   assign trig_c     = s3_vld && s3_armed && strat_en && (s3_qty != '0) && px_ok_c;
   assign clip_qty_c = (s3_qty < s3_cap) ? s3_qty : s3_cap;
   assign load_c     = advance_c && s3_valid && trig_c;
   assign drop_c     = advance_c && s3_valid && !trig_c;
   assign arm_clr_c  = load_c && s3_os;

   // Table storage without reset; reads in the same cycle see old data.
   always_ff @(posedge clk) begin
      if (wr_map_c) map_idx[host_sym_c] <= host_wdata[IDX_WIDTH-1:0];
      if (wr_price_c) begin
         thr_mem[host_idx_c]  <= host_wdata[PRICE_WIDTH-1:0];
         side_mem[host_idx_c] <= host_wdata[PRICE_WIDTH];
         os_mem[host_idx_c]   <= host_wdata[PRICE_WIDTH+1];
      end
      if (wr_cap_c)  cap_mem[host_idx_c]  <= host_wdata[QTY_WIDTH-1:0];
      if (wr_tmpl_c) tmpl_mem[host_idx_c] <= host_wdata;
   end

   // Symbol-map valid bits and arming; a host price write re-arms after a clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         map_vld <= '0;
         armed   <= '0;
      end else begin
         if (wr_map_c) map_vld[host_sym_c] <= host_wdata[IDX_WIDTH];
         if (arm_clr_c) armed[s3_idx] <= 1'b0;
         if (wr_price_c) armed[host_idx_c] <= 1'b1;
      end
   end

   // Three-stage pipeline; a disarm at S3 is forwarded to the entry read at S2.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0; s1_sym <= '0; s1_price <= '0; s1_qty <= '0;
         s2_valid <= 1'b0; s2_vld <= 1'b0; s2_idx <= '0; s2_price <= '0; s2_qty <= '0;
         s3_valid <= 1'b0; s3_vld <= 1'b0; s3_idx <= '0; s3_price <= '0; s3_qty <= '0;
         s3_thr <= '0; s3_side <= 1'b0; s3_os <= 1'b0; s3_armed <= 1'b0;
         s3_cap <= '0; s3_tmpl <= '0;
      end else if (advance_c) begin
         s1_valid <= tick_valid;
         s1_sym   <= tick_sym;
         s1_price <= tick_price;
         s1_qty   <= tick_qty;
         s2_valid <= s1_valid;
         s2_vld   <= map_vld[s1_sym];
         s2_idx   <= map_idx[s1_sym];
         s2_price <= s1_price;
         s2_qty   <= s1_qty;
         s3_valid <= s2_valid;
         s3_vld   <= s2_vld;
         s3_idx   <= s2_idx;
         s3_price <= s2_price;
         s3_qty   <= s2_qty;
         s3_thr   <= thr_mem[s2_idx];
         s3_side  <= side_mem[s2_idx];
         s3_os    <= os_mem[s2_idx];
         s3_cap   <= cap_mem[s2_idx];
         s3_tmpl  <= tmpl_mem[s2_idx];
         s3_armed <= armed[s2_idx] && !(arm_clr_c && (s3_idx == s2_idx));
      end
   end

   // Output register; payload holds while the order waits for ord_ready.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ord_valid <= 1'b0;
         ord_tmpl  <= '0;
         ord_price <= '0;
         ord_qty   <= '0;
         ord_idx   <= '0;
      end else if (advance_c) begin
         ord_valid <= load_c;
         if (load_c) begin
            ord_tmpl  <= s3_tmpl;
            ord_price <= s3_price;
            ord_qty   <= clip_qty_c;
            ord_idx   <= s3_idx;
         end
      end
   end

`ifdef TTS_EVAL_STATS_EN
   // Saturating statistics counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_ticks  <= '0;
         stat_orders <= '0;
         stat_drops  <= '0;
      end else begin
         if (tick_acc_c && (stat_ticks != '1))  stat_ticks  <= stat_ticks + 32'd1;
         if (load_c && (stat_orders != '1))     stat_orders <= stat_orders + 32'd1;
         if (drop_c && (stat_drops != '1))      stat_drops  <= stat_drops + 32'd1;
      end
   end
`else
   logic unused_stats_c;
   assign unused_stats_c = tick_acc_c ^ drop_c;
   assign stat_ticks  = '0;
   assign stat_orders = '0;
   assign stat_drops  = '0;
`endif

endmodule

// File: tb/tb_tts_eval.sv
// tb_tts_eval: directed bench for tts_eval (symbol mapping, buy/sell triggers,
// one-shot arming, stall behaviour, drop conditions, mid-stream reset).
`timescale 1ns/1ps

module tb_tts_eval;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        tick_valid;
   logic        tick_ready;
   logic [7:0]  tick_sym;
   logic [31:0] tick_price;
   logic [31:0] tick_qty;
   logic        strat_en;
   logic        host_wr;
   logic [1:0]  host_sel;
   logic [7:0]  host_addr;
   logic [63:0] host_wdata;
   logic        ord_valid;
   logic        ord_ready;
   logic [63:0] ord_tmpl;
   logic [31:0] ord_price;
   logic [31:0] ord_qty;
   logic [5:0]  ord_idx;
   logic [31:0] stat_ticks;
   logic [31:0] stat_orders;
   logic [31:0] stat_drops;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   localparam logic [63:0] TMPL5 = 64'hCAFE_0000_1234_0005;

   tts_eval dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick_valid (tick_valid),
      .tick_ready (tick_ready),
      .tick_sym   (tick_sym),
      .tick_price (tick_price),
      .tick_qty   (tick_qty),
      .strat_en   (strat_en),
      .host_wr    (host_wr),
      .host_sel   (host_sel),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .ord_valid  (ord_valid),
      .ord_ready  (ord_ready),
      .ord_tmpl   (ord_tmpl),
      .ord_price  (ord_price),
      .ord_qty    (ord_qty),
      .ord_idx    (ord_idx),
      .stat_ticks (stat_ticks),
      .stat_orders(stat_orders),
      .stat_drops (stat_drops)
   );

   always #5 clk = ~clk;

   // Expected counter value for the current build (counters tie to 0 when disabled).
   function automatic logic [31:0] ev(input int unsigned v);
`ifdef TTS_EVAL_STATS_EN
      return 32'(v);
`else
      return 32'(v & 0);
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_order(input string tag, input logic [31:0] p, input logic [31:0] q);
      chk({tag, "_valid"}, 64'(ord_valid), 64'd1);
      chk({tag, "_price"}, 64'(ord_price), 64'(p));
      chk({tag, "_qty"},   64'(ord_qty),   64'(q));
      chk({tag, "_idx"},   64'(ord_idx),   64'd5);
   endtask

   task automatic chk_stats(input string tag, input int unsigned t, input int unsigned o,
                            input int unsigned d);
      chk({tag, "_ticks"},  64'(stat_ticks),  64'(ev(t)));
      chk({tag, "_orders"}, 64'(stat_orders), 64'(ev(o)));
      chk({tag, "_drops"},  64'(stat_drops),  64'(ev(d)));
   endtask

   task automatic host_write(input logic [1:0] sel, input logic [7:0] addr, input logic [63:0] data);
      host_wr = 1'b1; host_sel = sel; host_addr = addr; host_wdata = data;
      @(negedge clk);
      host_wr = 1'b0;
   endtask

   // Present one tick for one cycle; returns at the negedge after its acceptance edge.
   task automatic send(input logic [7:0] sym, input logic [31:0] p, input logic [31:0] q);
      tick_valid = 1'b1; tick_sym = sym; tick_price = p; tick_qty = q;
      @(negedge clk);
      tick_valid = 1'b0;
   endtask

   // Send a tick and check that no order appears at the three-edge latency point.
   task automatic send_no_order(input string tag, input logic [7:0] sym, input logic [31:0] p,
                                input logic [31:0] q);
      send(sym, p, q);
      repeat (3) @(negedge clk);
      chk(tag, 64'(ord_valid), 64'd0);
   endtask

   initial begin
      reset_n = 1'b0; tick_valid = 1'b0; tick_sym = '0; tick_price = '0; tick_qty = '0;
      strat_en = 1'b1; host_wr = 1'b0; host_sel = '0; host_addr = '0; host_wdata = '0;
      ord_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ord_valid", 64'(ord_valid), 64'd0);
      chk("rst_ord_qty", 64'(ord_qty), 64'd0);
      chk_stats("rst", 0, 0, 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_tick_ready", 64'(tick_ready), 64'd1);

      // Setup: sym 0x12 -> idx 5, buy at <=100, cap 50.
      host_write(2'd0, 8'h12, 64'h45);
      host_write(2'd1, 8'd5, 64'd100);
      host_write(2'd2, 8'd5, 64'd50);
      host_write(2'd3, 8'd5, TMPL5);

      // Buy trigger: latency three edges, qty clipped to cap.
      send(8'h12, 32'd99, 32'd80);
      repeat (2) @(negedge clk);
      chk("buy_early", 64'(ord_valid), 64'd0);
      @(negedge clk);
      chk_order("buy", 32'd99, 32'd50);
      chk("buy_tmpl", ord_tmpl, TMPL5);
      chk_stats("buy", 1, 1, 0);

      // Price above buy threshold -> drop.
      send_no_order("buy_above_thr", 8'h12, 32'd101, 32'd80);
      chk_stats("buy_drop", 2, 1, 1);

      // Price equal to threshold triggers; qty below cap passes through.
      send(8'h12, 32'd100, 32'd30);
      repeat (3) @(negedge clk);
      chk_order("buy_eq", 32'd100, 32'd30);

      // Sell one-shot at 100: back-to-back ticks at 120 give exactly one order.
      host_write(2'd1, 8'd5, 64'h3_0000_0064);
      tick_valid = 1'b1; tick_sym = 8'h12; tick_price = 32'd120; tick_qty = 32'd10;
      @(negedge clk);
      @(negedge clk);
      tick_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk_order("os_first", 32'd120, 32'd10);
      @(negedge clk);
      chk("os_second", 64'(ord_valid), 64'd0);
      chk_stats("os", 5, 3, 2);
      send_no_order("os_disarmed", 8'h12, 32'd120, 32'd10);

      // Rewriting the price entry re-arms it.
      host_write(2'd1, 8'd5, 64'h3_0000_0064);
      send(8'h12, 32'd120, 32'd10);
      repeat (3) @(negedge clk);
      chk_order("os_rearm", 32'd120, 32'd10);
      chk_stats("os_rearm", 7, 4, 3);

      // Stall: buy at <=1000, ord_ready low while four ticks are in flight.
      host_write(2'd1, 8'd5, 64'd1000);
      ord_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick_valid = 1'b1; tick_sym = 8'h12; tick_price = 32'(11 + i); tick_qty = 32'd5;
         @(negedge clk);
      end
      tick_price = 32'd15;
      for (int s = 0; s < 5; s++) begin
         chk("stall_ready", 64'(tick_ready), 64'd0);
         chk("stall_price", 64'(ord_price), 64'd11);
         if (s < 4) @(negedge clk);
      end
      chk("stall_valid", 64'(ord_valid), 64'd1);
      ord_ready = 1'b1;
      @(negedge clk);
      tick_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk_order("drain", 32'(12 + k), 32'd5);
         @(negedge clk);
      end
      chk("drain_end", 64'(ord_valid), 64'd0);
      chk_stats("drain", 12, 9, 3);

      // Drop conditions: unmapped symbol, global disarm, zero quantity.
      send_no_order("unmapped", 8'h13, 32'd5, 32'd5);
      strat_en = 1'b0;
      send_no_order("strat_off", 8'h12, 32'd5, 32'd5);
      strat_en = 1'b1;
      send_no_order("qty_zero", 8'h12, 32'd5, 32'd0);
      chk_stats("drops", 15, 9, 6);

      // Mid-stream reset with an order held and a tick in flight.
      ord_ready = 1'b0;
      send(8'h12, 32'd5, 32'd7);
      send(8'h12, 32'd6, 32'd7);
      repeat (2) @(negedge clk);
      chk("pre_rst_valid", 64'(ord_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(ord_valid), 64'd0);
      chk("mid_rst_qty", 64'(ord_qty), 64'd0);
      chk_stats("mid_rst", 0, 0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      ord_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 64'(tick_ready), 64'd1);
      chk("post_rst_valid", 64'(ord_valid), 64'd0);
      send_no_order("post_rst_unmapped", 8'h12, 32'd5, 32'd80);
      chk_stats("post_rst", 1, 0, 1);

      // Remap and re-arm; cap and template survive reset.
      host_write(2'd0, 8'h12, 64'h45);
      host_write(2'd1, 8'd5, 64'd1000);
      send(8'h12, 32'd5, 32'd80);
      repeat (3) @(negedge clk);
      chk_order("remap", 32'd5, 32'd50);
      chk("remap_tmpl", ord_tmpl, TMPL5);
      chk_stats("remap", 2, 1, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/tts_eval.md
# tts_eval

Parametrised, pipelined tick-to-trade strategy evaluator. It is the next-generation successor to the fixed-width strategy wrapper. It accepts decoded ticks over a valid/ready handshake and maps each symbol ID to a strategy index. It then reads per-index price threshold, quantity cap and order template, decides whether to trade, and emits an order with a clipped quantity. All tables are internal and host-writable; per-entry side mode and one-shot arming are new behaviour.

## Interface
Parameters:
- SYM_ID_WIDTH, 8: symbol ID width; symbol map depth 2**SYM_ID_WIDTH.
- IDX_WIDTH, 6: strategy index width; strategy table depth 2**IDX_WIDTH.
- PRICE_WIDTH, 32: tick/threshold price width, unsigned.
- QTY_WIDTH, 32: tick volume / quantity cap width, unsigned.
- ORDER_WIDTH, 64: order template width; must be >= PRICE_WIDTH+2, QTY_WIDTH and IDX_WIDTH+1.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick_valid  in  1  tick present.
- tick_ready  out  1  tick accepted when valid&ready.
- tick_sym  in  SYM_ID_WIDTH  symbol ID.
- tick_price  in  PRICE_WIDTH  tick price.
- tick_qty  in  QTY_WIDTH  tick volume.
- strat_en  in  1  global arm; 0 suppresses all triggers.
- host_wr  in  1  host table write strobe.
- host_sel  in  2  table select: 0 symbol map, 1 price, 2 qty cap, 3 order template.
- host_addr  in  max(SYM_ID_WIDTH,IDX_WIDTH)  table address; upper bits ignored for strategy tables.
- host_wdata  in  ORDER_WIDTH  write data, LSB-aligned.
- ord_valid  out  1  order present.
- ord_ready  in  1  order consumed when valid&ready.
- ord_tmpl  out  ORDER_WIDTH  order template.
- ord_price  out  PRICE_WIDTH  tick price echoed.
- ord_qty  out  QTY_WIDTH  min(tick_qty, cap).
- ord_idx  out  IDX_WIDTH  strategy index.
- stat_ticks, stat_orders, stat_drops  out  32 each  statistics counters.

## Operation
- Symbol map entry: {vld, idx}; host_wdata[IDX_WIDTH] = vld, host_wdata[IDX_WIDTH-1:0] = idx.
- Price entry: host_wdata[PRICE_WIDTH-1:0] = threshold, [PRICE_WIDTH] = side (0 buy, 1 sell), [PRICE_WIDTH+1] = one-shot.
- Any host write to a price entry sets armed[idx]=1.
- Pipeline stages:
  - S1 captures the tick and reads the symbol map.
  - S2 reads the price, cap, template and armed entries at idx.
  - S3 evaluates and loads the output register.
- Trigger = vld & armed & strat_en & tick_qty!=0 & (side ? price>=thr : price<=thr). Comparisons are unsigned, full width.
- On trigger: ord_qty = tick_qty<cap ? tick_qty : cap. If the entry is one-shot, armed[idx] is cleared as the order is loaded.
- Non-trigger: no order; stat_drops increments.
- One-shot bypass: when S3 clears armed[i] in the same cycle that S2 holds index i, S2 treats armed as 0. Back-to-back ticks on a one-shot entry therefore yield exactly one order.
- Stall: global advance = !ord_valid | ord_ready. tick_ready = advance. When advance=0, all stages hold and no table is re-read.
- Host writes are accepted every cycle, including during a stall. A write and a tick read of the same entry in the same cycle return the old data.
- Counters (32-bit, saturate at all-ones):
  - stat_ticks increments on tick acceptance.
  - stat_orders increments on order load.
  - stat_drops increments on a non-trigger at S3.
- Reset clears: all stage valids, ord_valid, all outputs (0), counters, armed[] and all symbol-map vld bits. Price, cap and template contents are not reset.

## Timing
- Latency: tick accepted at edge N -> ord_valid=1 after edge N+3 when there is no stall. Throughput is 1 tick/cycle.
- ord_* stays stable while ord_valid & !ord_ready.
- tick_ready is combinational from ord_valid/ord_ready only; there is no path from tick_valid.
- Assertion of reset_n low mid-operation drops in-flight ticks without counting them. tick_ready is 1 from the first cycle after release.

## Configuration
- TTS_EVAL_STATS_EN defined: the three counters are implemented as above.
- TTS_EVAL_STATS_EN undefined: no counter flops; stat_ticks, stat_orders and stat_drops are tied to 0.

## Test plan
- Setup: map sym 0x12 -> idx 5 (vld); price 5 = 100, buy, not one-shot; cap 5 = 50.
  - Tick (0x12, 99, 80) -> ord_valid after 3 cycles with ord_price=99, ord_qty=50, ord_idx=5.
  - Tick at price 101 -> no order; stat_drops=1.
- Sell one-shot: idx 5 set to sell/one-shot thr=100; two back-to-back ticks at price 120 -> exactly one order; the second tick is counted as a drop.
  - Host rewrites price 5 -> the next tick at price 120 fires again.
- Hold ord_ready=0 for 5 cycles with 4 ticks offered -> tick_ready=0 while ord_valid=1. After release, orders emerge in order with no loss or duplication.
- Unmapped sym 0x13 -> no order.
  - strat_en=0 with a valid trigger -> no order.
  - tick_qty=0 -> no order.
- Assert reset_n low mid-stream -> ord_valid=0 and counters=0 immediately. A previously mapped symbol then produces no order until the symbol map is rewritten.
